// File: rtl/uart_number_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_number_rx_if
// Description : Signal bundle between the serial number receiver and its
//               environment. The slave side is the receiver (takes rx,
//               drives results); the master side feeds rx and observes them.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_number_rx_if #(
    parameter int NUM_COLUMNS = 32
);
    logic                   rx;
    logic [7:0]             byte_data;
    logic                   byte_valid;
    logic [NUM_COLUMNS-1:0] word_data;
    logic                   word_valid;
    logic                   frame_err;
    logic                   format_err;
    logic                   busy;

    modport master (
        output rx,
        input  byte_data,
        input  byte_valid,
        input  word_data,
        input  word_valid,
        input  frame_err,
        input  format_err,
        input  busy
    );

    modport slave (
        input  rx,
        output byte_data,
        output byte_valid,
        output word_data,
        output word_valid,
        output frame_err,
        output format_err,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_number_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_number_rx
// Description : 8N1 UART receiver that turns lines of ASCII '0'/'1' digits
//               terminated by '\n' into NUM_COLUMNS-bit words. Bytes with a
//               bad stop bit raise frame_err; malformed lines raise
//               format_err. '\r' is ignored so CRLF lines are accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_number_rx #(
    parameter int CLKS_PER_BIT = 4000,
    parameter int NUM_COLUMNS  = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    uart_number_rx_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_timer_w = $clog2(CLKS_PER_BIT);
    localparam int c_cnt_w   = $clog2(NUM_COLUMNS + 1);

    localparam logic [c_timer_w-1:0] c_timer_one = c_timer_w'(1);
    localparam logic [c_timer_w-1:0] c_half_last = c_timer_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_timer_w-1:0] c_bit_last  = c_timer_w'(CLKS_PER_BIT - 1);

    localparam logic [c_cnt_w-1:0]   c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]   c_cnt_full  = c_cnt_w'(NUM_COLUMNS);

    localparam logic [7:0] c_chr_lf = 8'h0A;
    localparam logic [7:0] c_chr_cr = 8'h0D;

    // Receive FSM encoding
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_break = 3'd4;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic                   r_rx_meta;
    logic                   r_rxs;

    logic [2:0]             r_state;
    logic [c_timer_w-1:0]   r_timer;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic [7:0]             r_byte_data;
    logic                   r_byte_valid;
    logic                   r_frame_err;

    logic [c_cnt_w-1:0]     r_count;
    logic                   r_drop;
    logic [NUM_COLUMNS-1:0] r_line_shift;
    logic [NUM_COLUMNS-1:0] r_word_data;
    logic                   r_word_valid;
    logic                   r_format_err;

    logic                   w_is_digit;
    logic                   w_is_lf;
    logic                   w_is_cr;
    logic                   w_line_full;

    // ------------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------------

    // Two-flop synchroniser; presets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------------

    // Frame FSM: half-bit wait to find mid-start, then one full bit per sample.
    // The stop bit is sampled mid-bit so IDLE is back in time for a start
    // edge that follows a single stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_timer <= '0;
                    if (!r_rxs) begin
                        r_state <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (r_timer == c_half_last) begin
                        r_timer <= '0;
                        if (!r_rxs) begin
                            r_state   <= c_st_data;
                            r_bit_idx <= '0;
                        end else begin
                            // Line went back high before mid-start: a glitch.
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_timer <= r_timer + c_timer_one;
                    end
                end
                c_st_data: begin
                    if (r_timer == c_bit_last) begin
                        r_timer <= '0;
                        r_shift <= {r_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_st_stop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + c_timer_one;
                    end
                end
                c_st_stop: begin
                    if (r_timer == c_bit_last) begin
                        r_timer <= '0;
                        if (r_rxs) begin
                            r_byte_data  <= r_shift;
                            r_byte_valid <= 1'b1;
                            r_state      <= c_st_idle;
                        end else begin
                            // Bad stop bit: drop the byte and wait out the low line.
                            r_frame_err <= 1'b1;
                            r_state     <= c_st_break;
                        end
                    end else begin
                        r_timer <= r_timer + c_timer_one;
                    end
                end
                c_st_break: begin
                    r_timer <= '0;
                    if (r_rxs) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Line assembler
    // ------------------------------------------------------------------------

    // ASCII '0' is 0x30 and '1' is 0x31, so bit 0 is the digit value.
    assign w_is_digit  = (r_byte_data[7:1] == 7'b0011000);
    assign w_is_lf     = (r_byte_data == c_chr_lf);
    assign w_is_cr     = (r_byte_data == c_chr_cr);
    assign w_line_full = (r_count == c_cnt_full);

    // Collect digits per line; once a line is known bad it is dropped until '\n'
    // so only one format_err is reported per malformed line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_drop       <= 1'b0;
            r_line_shift <= '0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_format_err <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            r_format_err <= 1'b0;
            if (r_byte_valid) begin
                if (w_is_digit) begin
                    if (!r_drop) begin
                        if (w_line_full) begin
                            r_format_err <= 1'b1;
                            r_drop       <= 1'b1;
                        end else begin
                            r_line_shift <= {r_line_shift[NUM_COLUMNS-2:0], r_byte_data[0]};
                            r_count      <= r_count + c_cnt_one;
                        end
                    end
                end else if (w_is_lf) begin
                    if (!r_drop) begin
                        if (w_line_full) begin
                            r_word_data  <= r_line_shift;
                            r_word_valid <= 1'b1;
                        end else begin
                            r_format_err <= 1'b1;
                        end
                    end
                    r_count <= '0;
                    r_drop  <= 1'b0;
                end else if (w_is_cr) begin
                    // Carriage return carries no information.
                    r_drop <= r_drop;
                end else begin
                    if (!r_drop) begin
                        r_format_err <= 1'b1;
                        r_drop       <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.byte_data  = r_byte_data;
    assign bus.byte_valid = r_byte_valid;
    assign bus.word_data  = r_word_data;
    assign bus.word_valid = r_word_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.format_err = r_format_err;
    assign bus.busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_number_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_number_rx
// Description : Self-checking bench for uart_number_rx. A serial driver sends
//               directed lines; expected bytes/words are queued as they are
//               sent and compared when the receiver reports them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_number_rx;

    localparam int CPB = 16;
    localparam int NC  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_number_rx_if #(.NUM_COLUMNS(NC)) bus ();

    uart_number_rx #(
        .CLKS_PER_BIT (CPB),
        .NUM_COLUMNS  (NC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]    byte_q[$];
    logic [NC-1:0] word_q[$];

    int byte_cnt   = 0;
    int word_cnt   = 0;
    int frame_cnt  = 0;
    int format_cnt = 0;

    int b0, w0, fr0, fm0;
    logic [7:0] last_byte;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop and compare whenever the receiver reports a result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.byte_valid) begin
                byte_cnt++;
                if (byte_q.size() == 0) check("byte_unexpected", 64'(bus.byte_valid), 64'd0);
                else                    check("byte_data", 64'(bus.byte_data), 64'(byte_q.pop_front()));
            end
            if (bus.word_valid) begin
                word_cnt++;
                if (word_q.size() == 0) check("word_unexpected", 64'(bus.word_valid), 64'd0);
                else                    check("word_data", 64'(bus.word_data), 64'(word_q.pop_front()));
            end
            if (bus.frame_err)  frame_cnt++;
            if (bus.format_err) format_cnt++;
        end
    end

    // One 8N1 frame; bit periods alternate p0, p1 starting with the start bit.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int p0, input int p1);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        if (stop_ok) byte_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            bus.rx = bits[i];
            repeat ((i % 2 == 0) ? p0 : p1) @(negedge clk);
        end
        if (stop_ok) bus.rx = 1'b1;
    endtask

    task automatic send_line(input logic [NC-1:0] w, input int ndig, input bit crlf,
                             input bit expect_word, input int p0, input int p1);
        for (int i = 0; i < ndig; i++) begin
            send_byte(w[NC-1-(i % NC)] ? 8'h31 : 8'h30, 1'b1, p0, p1);
        end
        if (crlf) send_byte(8'h0D, 1'b1, p0, p1);
        if (expect_word) word_q.push_back(w);
        send_byte(8'h0A, 1'b1, p0, p1);
        repeat (40) @(negedge clk);
    endtask

    task automatic snap();
        b0 = byte_cnt; w0 = word_cnt; fr0 = frame_cnt; fm0 = format_cnt;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_byte_data"},  64'(bus.byte_data),  64'd0);
        check({tag, "_byte_valid"}, 64'(bus.byte_valid), 64'd0);
        check({tag, "_word_data"},  64'(bus.word_data),  64'd0);
        check({tag, "_word_valid"}, 64'(bus.word_valid), 64'd0);
        check({tag, "_frame_err"},  64'(bus.frame_err),  64'd0);
        check({tag, "_format_err"}, 64'(bus.format_err), 64'd0);
        check({tag, "_busy"},       64'(bus.busy),       64'd0);
    endtask

    initial begin
        logic [7:0] part;
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean line, back-to-back frames
        snap();
        send_line(32'h8000_102B, NC, 1'b0, 1'b1, CPB, CPB);
        check("clean_bytes",  64'(byte_cnt - b0),    64'd33);
        check("clean_words",  64'(word_cnt - w0),    64'd1);
        check("clean_frame",  64'(frame_cnt - fr0),  64'd0);
        check("clean_format", 64'(format_cnt - fm0), 64'd0);

        // Glitch while idle, then CRLF line
        snap();
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_busy_start", 64'(bus.busy), 64'd1);
        repeat (6) @(negedge clk);
        check("glitch_busy_idle", 64'(bus.busy), 64'd0);
        repeat (30) @(negedge clk);
        check("glitch_bytes", 64'(byte_cnt - b0),   64'd0);
        check("glitch_frame", 64'(frame_cnt - fr0), 64'd0);
        send_line(32'h8000_102B, NC, 1'b1, 1'b1, CPB, CPB);
        check("crlf_bytes",  64'(byte_cnt - b0),    64'd34);
        check("crlf_words",  64'(word_cnt - w0),    64'd1);
        check("crlf_format", 64'(format_cnt - fm0), 64'd0);
        last_byte = 8'h0A;

        // Bad stop bit, line held low, then 'A'
        snap();
        send_byte(8'h55, 1'b0, CPB, CPB);
        repeat (40) @(negedge clk);
        check("break_busy_low",  64'(bus.busy),          64'd1);
        check("break_frame_err", 64'(frame_cnt - fr0),   64'd1);
        check("break_no_byte",   64'(byte_cnt - b0),     64'd0);
        check("break_byte_hold", 64'(bus.byte_data),     64'(last_byte));
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        check("break_busy_released", 64'(bus.busy), 64'd0);
        send_byte(8'h41, 1'b1, CPB, CPB);
        repeat (20) @(negedge clk);
        check("after_break_bytes",  64'(byte_cnt - b0),    64'd1);
        check("after_break_format", 64'(format_cnt - fm0), 64'd1);
        check("after_break_frame",  64'(frame_cnt - fr0),  64'd1);
        send_byte(8'h0A, 1'b1, CPB, CPB);
        repeat (20) @(negedge clk);
        check("dropped_lf_format", 64'(format_cnt - fm0), 64'd1);
        check("dropped_lf_words",  64'(word_cnt - w0),    64'd0);

        // Short line
        snap();
        send_line(32'h1234_5678, NC - 1, 1'b0, 1'b0, CPB, CPB);
        check("short_format", 64'(format_cnt - fm0), 64'd1);
        check("short_words",  64'(word_cnt - w0),    64'd0);

        // Long line: only the 33rd digit reports
        snap();
        send_line(32'hDEAD_BEEF, NC + 1, 1'b0, 1'b0, CPB, CPB);
        check("long_format", 64'(format_cnt - fm0), 64'd1);
        check("long_words",  64'(word_cnt - w0),    64'd0);

        // Recovery line
        snap();
        send_line(32'hCAFE_0001, NC, 1'b0, 1'b1, CPB, CPB);
        check("recover_words",  64'(word_cnt - w0),    64'd1);
        check("recover_format", 64'(format_cnt - fm0), 64'd0);

        // Reset during bit 4 of the 10th digit
        for (int i = 0; i < 9; i++) begin
            send_byte((32'h8000_102B >> (NC - 1 - i)) & 1 ? 8'h31 : 8'h30, 1'b1, CPB, CPB);
        end
        part = 8'h30;
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = part[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = part[4];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_outputs_zero("midline_reset");
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        check_outputs_zero("midline_reset_hold");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        snap();
        send_line(32'h8000_102B, NC, 1'b0, 1'b1, CPB, CPB);
        check("post_reset_words",  64'(word_cnt - w0),    64'd1);
        check("post_reset_format", 64'(format_cnt - fm0), 64'd0);

        // Transmitter bit periods of 15 and 17 cycles
        snap();
        send_line(32'h5A5A_0FF0, NC, 1'b0, 1'b1, CPB - 1, CPB + 1);
        send_line(32'hA5A5_F00F, NC, 1'b0, 1'b1, CPB + 1, CPB - 1);
        check("baud_words",  64'(word_cnt - w0),    64'd2);
        check("baud_format", 64'(format_cnt - fm0), 64'd0);
        check("baud_frame",  64'(frame_cnt - fr0),  64'd0);

        check("byte_q_drained", 64'(byte_q.size()), 64'd0);
        check("word_q_drained", 64'(word_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_number_rx.md
Name: uart_number_rx

Overview:
- Receive side of the board's 8N1 serial number stream on a user pin.
- Each line carries NUM_COLUMNS ASCII '0'/'1' characters, MSB first, terminated by '\n'.
- The block deserialises UART frames, validates framing, and assembles each line into a NUM_COLUMNS-bit word.
- The word is presented with a one-cycle valid pulse for downstream PRBS checking or LED display.

Parameters:
- CLKS_PER_BIT, 4000, clk cycles per UART bit (48 MHz / 4000 = 12000 baud); must be >= 8.
- NUM_COLUMNS, 32, binary digits per line; word width.

Ports:
- clk  input  1  system clock (48 MHz, global buffer)
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  serial line from user pin; idle high; asynchronous to clk
- byte_data  output  8  last correctly framed received byte
- byte_valid  output  1  one-cycle pulse when byte_data updates
- word_data  output  NUM_COLUMNS  last assembled word; bit NUM_COLUMNS-1 = first digit received
- word_valid  output  1  one-cycle pulse when word_data updates
- frame_err  output  1  one-cycle pulse on bad stop bit
- format_err  output  1  one-cycle pulse on malformed line
- busy  output  1  high whenever the receive FSM is not in IDLE

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0.
  - Synchroniser flops preset to 1.
  - FSM in IDLE; digit count 0; drop flag 0.
- Input conditioning: rx passes through a 2-flop synchroniser; rxs is the second-flop output. All sampling uses rxs.
- Bit timer: down/up counter of width $clog2(CLKS_PER_BIT), reloaded on every state entry.
- FSM states and transitions:
  - IDLE: rxs==0 -> START, timer cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample rxs.
    - 0 -> DATA, bit index 0.
    - 1 -> IDLE (glitch rejected, no error).
  - DATA: every CLKS_PER_BIT cycles, sample rxs into shift register, LSB first. After bit index 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - 1 -> byte_data <= shift register, byte_valid pulse next cycle, -> IDLE.
    - 0 -> frame_err pulse, byte discarded (byte_data unchanged), -> BREAK.
  - BREAK: wait for rxs==1, then -> IDLE. No byte or error generated while in BREAK.
- Sample point is mid-bit. Back-to-back frames with a single stop bit must be received without loss: IDLE is re-entered half a bit before the next start edge.
- Line assembler (acts in the cycle byte_valid is high; its outputs appear the following cycle):
  - '0' (0x30) / '1' (0x31):
    - If drop==0 and count<NUM_COLUMNS: shift = {shift[NUM_COLUMNS-2:0], digit}, count+1.
    - If drop==0 and count==NUM_COLUMNS: format_err pulse, drop<=1.
    - If drop==1: ignored.
  - '\n' (0x0A):
    - If drop==0 and count==NUM_COLUMNS: word_data <= shift, word_valid pulse.
    - If drop==0 and count!=NUM_COLUMNS (including count 0): format_err pulse.
    - If drop==1: no pulse.
    - In all cases count<=0, drop<=0.
  - '\r' (0x0D): ignored, no state change.
  - Any other byte:
    - If drop==0: format_err pulse, drop<=1.
    - If drop==1: ignored.
- frame_err does not affect the assembler. A missing byte therefore surfaces as format_err at the '\n'.
- Latency:
  - word_valid is exactly 1 cycle after the byte_valid of the terminating '\n'.
  - byte_valid is 1 cycle after the stop-bit sample.
- word_data and byte_data hold their value until the next valid pulse.
- Reset mid-frame or mid-line: immediate return to reset state. The partial byte and partial word are lost, and no pulses are emitted.

Test Plan:
- Use CLKS_PER_BIT=16, NUM_COLUMNS=32 for all scenarios.
- Clean line: send 32 digits of 0x8000_102B followed by '\n', frames back-to-back -> 33 byte_valid pulses; one word_valid with word_data=32'h8000_102B; no errors.
- CRLF and glitch: send the same line ending in "\r\n", plus a 4-cycle low glitch on rx while idle -> one word_valid with the same word; glitch produces no byte_valid, no frame_err, and no START->DATA transition.
- Framing: a frame with stop bit 0, then rx held low 40 cycles, then normal 'A' (0x41) -> frame_err once; busy stays high until rx returns high; next byte_data=0x41 with byte_valid; format_err pulse from 'A'.
- Short and long lines:
  - 31 digits + '\n' -> format_err at '\n', no word_valid.
  - 33 digits + '\n' -> format_err at the 33rd digit only; no second pulse at '\n'; no word_valid.
  - A following correct line produces a word normally.
- Reset mid-line: assert rst_n low during bit 4 of the 10th digit, release, then send a full valid line -> all outputs 0 during reset; exactly one correct word_valid afterwards; no format_err.
- Baud tolerance: transmitter bit period 15 and 17 cycles (±6%) on a valid line -> correct word in both cases.
